// File: rtl/lut_neuron_pkg.sv
// rtl/lut_neuron_pkg.sv - shared constants, FSM state type and slice helper for the LUT neuron bank
package lut_neuron_pkg;

    localparam int DEF_IN_WIDTH  = 6;
    localparam int DEF_OUT_WIDTH = 2;
    localparam int DEF_NUM_CH    = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - one neuron truth table: sync write, async read distributed RAM
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int ADDR_W = DEF_IN_WIDTH,
    parameter int DATA_W = DEF_OUT_WIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read: a same-edge write is only visible on the following cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_bank.sv
// rtl/lut_neuron_bank.sv - runtime-programmable bank of LUT neurons with clear FSM and output register
module lut_neuron_bank
    import lut_neuron_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*IN_WIDTH-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
    input  logic                          cfg_we,
    input  logic [CH_W-1:0]               cfg_ch,
    input  logic [IN_WIDTH-1:0]           cfg_addr,
    input  logic [OUT_WIDTH-1:0]          cfg_data,
    output logic                          cfg_ready,
    output logic                          init_done
);

    state_t                      state;
    logic [IN_WIDTH-1:0]         clr_cnt;
    logic [IN_WIDTH-1:0]         waddr;
    logic [OUT_WIDTH-1:0]        wdata;
    logic [NUM_CH*OUT_WIDTH-1:0] lookup;
    logic                        accept;

    assign cfg_ready = (state == RUN);
    assign init_done = (state == RUN);
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Clearing owns the write port; config writes are dropped until RUN.
    assign waddr = (state == CLEAR) ? clr_cnt : cfg_addr;
    assign wdata = (state == CLEAR) ? '0 : cfg_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                 ch_we;
        logic [OUT_WIDTH-1:0] rd;

        assign ch_we = (state == CLEAR) || (cfg_we && (state == RUN) && (cfg_ch == CH_W'(c)));

        lut_neuron_ram #(
            .ADDR_W(IN_WIDTH),
            .DATA_W(OUT_WIDTH)
        ) u_ram (
            .clk  (clk),
            .we   (ch_we),
            .waddr(waddr),
            .wdata(wdata),
            .raddr(in_data[slice_lo(c, IN_WIDTH) +: IN_WIDTH]),
            .rdata(rd)
        );

        assign lookup[slice_lo(c, OUT_WIDTH) +: OUT_WIDTH] = rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {IN_WIDTH{1'b1}}) begin
                        state <= RUN;
                    end
                end
                RUN: state <= RUN;
                default: state <= CLEAR;
            endcase

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= lookup;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
